// File: rtl/int4_operand_loader_pkg.sv
// Shared INT4 accelerator constants, common to the operand loader and the MAC.
package int4_operand_loader_pkg;

  localparam int ACC_LANE_W        = 4;
  localparam int ACC_LANES_PER_BEAT = 8;
  localparam int ACC_BEAT_W        = ACC_LANE_W * ACC_LANES_PER_BEAT;
  localparam int ACC_BEATS         = 8;
  localparam int ACC_DATA_W        = ACC_BEAT_W * ACC_BEATS;
  localparam int ACC_VEC_W         = 264;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/int4_operand_loader.sv
// Assembles BEATS input beats of packed INT4 A/B operands into one vector pair
// and issues it to the MAC with first/last framing and a per-dot-product count.
module int4_operand_loader
  import int4_operand_loader_pkg::*;
#(
  parameter int BEAT_W = ACC_BEAT_W,
  parameter int BEATS  = ACC_BEATS,
  parameter int VEC_W  = ACC_VEC_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_a,
  input  logic [BEAT_W-1:0] in_b,
  input  logic              in_last,
  input  logic              hold,
  input  logic              flush,
  output logic [VEC_W-1:0]  a_vec,
  output logic [VEC_W-1:0]  b_vec,
  output logic              int4_en,
  output logic              out_first,
  output logic              out_last,
  output logic [7:0]        vec_cnt,
  output logic              err
);

  localparam int DATA_W = BEAT_W * BEATS;
  localparam int CNT_W  = $clog2(BEATS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  logic              ready_q;
  logic              first_pend;
  logic [CNT_W-1:0]  beat_cnt;
  logic [DATA_W-1:0] asm_a, asm_b;
  logic [DATA_W-1:0] full_a, full_b;
  logic              accept, is_final, frame_err, issue;

  assign in_ready  = ready_q & ~hold & ~flush;
  assign accept    = in_valid & in_ready;
  assign is_final  = (beat_cnt == LAST_BEAT);
  assign frame_err = accept & in_last & ~is_final;
  assign issue     = accept & is_final;

  // The final beat bypasses the assembly registers so it lands in the issued vector on the same edge.
  always_comb begin
    full_a = asm_a;
    full_b = asm_b;
    full_a[DATA_W-1 -: BEAT_W] = in_a;
    full_b[DATA_W-1 -: BEAT_W] = in_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q    <= 1'b0;
      first_pend <= 1'b1;
      beat_cnt   <= '0;
      asm_a      <= '0;
      asm_b      <= '0;
      a_vec      <= '0;
      b_vec      <= '0;
      int4_en    <= 1'b0;
      out_first  <= 1'b0;
      out_last   <= 1'b0;
      vec_cnt    <= '0;
      err        <= 1'b0;
    end else begin
      ready_q   <= 1'b1;
      int4_en   <= issue;
      out_first <= issue & first_pend;
      out_last  <= issue & in_last;

      if (flush) begin
        beat_cnt   <= '0;
        first_pend <= 1'b1;
      end else if (frame_err) begin
        err        <= 1'b1;
        beat_cnt   <= '0;
        first_pend <= 1'b1;
      end else if (accept) begin
        asm_a[int'(beat_cnt)*BEAT_W +: BEAT_W] <= in_a;
        asm_b[int'(beat_cnt)*BEAT_W +: BEAT_W] <= in_b;
        beat_cnt <= is_final ? '0 : beat_cnt + 1'b1;
        if (is_final) begin
          a_vec      <= {{(VEC_W-DATA_W){1'b0}}, full_a};
          b_vec      <= {{(VEC_W-DATA_W){1'b0}}, full_b};
          first_pend <= in_last;
        end
      end

      // An issue can never coincide with the post-last clear: issues are BEATS accepts apart.
      if (issue) begin
        vec_cnt <= first_pend ? 8'd1 : sat_inc(vec_cnt);
      end else if (int4_en && out_last) begin
        vec_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_int4_operand_loader.sv
// Bench for int4_operand_loader: directed framing scenarios plus random traffic
// checked against a queue-based reference model of vector assembly.
module tb_int4_operand_loader;
  import int4_operand_loader_pkg::*;

  localparam int VW = ACC_VEC_W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          in_valid = 1'b0, in_last = 1'b0, hold = 1'b0, flush = 1'b0;
  logic [31:0]   in_a = '0, in_b = '0;
  logic          in_ready, int4_en, out_first, out_last, err;
  logic [VW-1:0] a_vec, b_vec;
  logic [7:0]    vec_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  int4_operand_loader dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .hold(hold), .flush(flush),
    .a_vec(a_vec), .b_vec(b_vec), .int4_en(int4_en), .out_first(out_first),
    .out_last(out_last), .vec_cnt(vec_cnt), .err(err)
  );

  // reference model state
  logic [31:0]   mq_a[$], mq_b[$];
  bit            m_started, m_first_pend, m_err, m_en, m_first, m_last;
  int            m_cnt;
  logic [VW-1:0] m_a, m_b;
  int            cyc;
  int            en_cyc[$];

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq_a.delete(); mq_b.delete();
    m_started = 0; m_first_pend = 1; m_err = 0;
    m_en = 0; m_first = 0; m_last = 0; m_cnt = 0;
    m_a = '0; m_b = '0;
  endtask

  task automatic check_outputs();
    chk("int4_en", int4_en, m_en);
    chk("out_first", out_first, m_first);
    chk("out_last", out_last, m_last);
    chk("vec_cnt", vec_cnt, m_cnt);
    chk("err", err, m_err);
    chk("a_vec", a_vec, m_a);
    chk("b_vec", b_vec, m_b);
  endtask

  task automatic cycle();
    bit rdy, acc, nen, nfirst, nlast;
    #1;
    rdy = m_started && !hold && !flush;
    chk("in_ready", in_ready, rdy);
    acc = in_valid && rdy;
    nen = 0; nfirst = 0; nlast = 0;
    if (m_en && m_last) m_cnt = 0;
    if (flush) begin
      mq_a.delete(); mq_b.delete();
      m_first_pend = 1;
    end else if (acc) begin
      if (in_last && mq_a.size() != 7) begin
        m_err = 1;
        mq_a.delete(); mq_b.delete();
        m_first_pend = 1;
      end else begin
        mq_a.push_back(in_a);
        mq_b.push_back(in_b);
        if (mq_a.size() == 8) begin
          m_a = '0; m_b = '0;
          for (int k = 0; k < 8; k++) begin
            m_a[32*k +: 32] = mq_a[k];
            m_b[32*k +: 32] = mq_b[k];
          end
          nen = 1; nfirst = m_first_pend; nlast = in_last;
          m_cnt = m_first_pend ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
          m_first_pend = in_last;
          mq_a.delete(); mq_b.delete();
        end
      end
    end
    m_en = nen; m_first = nfirst; m_last = nlast;
    @(posedge clk);
    m_started = 1;
    cyc++;
    @(negedge clk);
    if (int4_en) en_cyc.push_back(cyc + 1);
    check_outputs();
  endtask

  task automatic beat(input logic [31:0] a, input logic [31:0] b, input bit last);
    in_valid = 1; in_a = a; in_b = b; in_last = last; hold = 0; flush = 0;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 0; in_last = 0; hold = 0; flush = 0;
      cycle();
    end
  endtask

  // Asserts reset asynchronously, checks the cleared outputs at once, then releases it.
  task automatic do_reset();
    rst_n = 0; in_valid = 0; in_last = 0; hold = 0; flush = 0;
    #1;
    model_reset();
    chk("rst_in_ready", in_ready, 1'b0);
    check_outputs();
    @(negedge clk);
    rst_n = 1;
    idle(1);
  endtask

  function automatic int en_at(input int i);
    return (en_cyc.size() > i) ? en_cyc[i] : -1;
  endfunction

  logic [VW-1:0] exp_vec;

  initial begin
    #2;
    // single vector with a fixed pattern
    do_reset();
    for (int k = 0; k < 8; k++) beat(32'h7654_3210, 32'h1111_1111, k == 7);
    exp_vec = {8'h00, {8{32'h7654_3210}}};
    chk("s1_en", int4_en, 1'b1);
    chk("s1_a_vec", a_vec, exp_vec);
    exp_vec = {8'h00, {8{32'h1111_1111}}};
    chk("s1_b_vec", b_vec, exp_vec);
    chk("s1_first", out_first, 1'b1);
    chk("s1_last", out_last, 1'b1);
    chk("s1_cnt", vec_cnt, 8'd1);
    idle(1);
    chk("s1_en_off", int4_en, 1'b0);
    chk("s1_cnt_clr", vec_cnt, 8'd0);

    // three back-to-back vectors
    do_reset();
    cyc = 0; en_cyc.delete();
    for (int k = 0; k < 24; k++) beat($urandom, $urandom, k == 23);
    idle(3);
    chk("s2_n_issue", en_cyc.size(), 3);
    chk("s2_issue0", en_at(0), 9);
    chk("s2_issue1", en_at(1), 17);
    chk("s2_issue2", en_at(2), 25);

    // hold for 5 cycles after beat 3
    do_reset();
    cyc = 0; en_cyc.delete();
    for (int k = 0; k < 4; k++) beat($urandom, $urandom, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; hold = 1; in_last = 0; in_a = $urandom; in_b = $urandom;
      cycle();
    end
    for (int k = 4; k < 8; k++) beat($urandom, $urandom, k == 7);
    idle(2);
    chk("s3_issue", en_at(0), 14);

    // framing error on beat 4
    do_reset();
    en_cyc.delete();
    for (int k = 0; k < 5; k++) beat($urandom, $urandom, k == 4);
    chk("s4_err", err, 1'b1);
    idle(2);
    for (int k = 0; k < 8; k++) beat($urandom, $urandom, k == 7);
    chk("s4_first", out_first, 1'b1);
    idle(2);
    chk("s4_n_issue", en_cyc.size(), 1);
    chk("s4_err_sticky", err, 1'b1);

    // flush after beat 5
    do_reset();
    en_cyc.delete();
    for (int k = 0; k < 6; k++) beat(32'hDEAD_0000 + k, 32'hBEEF_0000 + k, 0);
    in_valid = 1; flush = 1; in_a = 32'hFFFF_FFFF; in_b = 32'hFFFF_FFFF; in_last = 0;
    cycle();
    for (int k = 0; k < 8; k++) beat(32'hA5A5_0000 + k, 32'h5A5A_0000 + k, 0);
    idle(2);
    chk("s5_n_issue", en_cyc.size(), 1);
    chk("s5_a_beat0", a_vec[31:0], 32'hA5A5_0000);

    // reset after beat 6
    for (int k = 0; k < 7; k++) beat($urandom, $urandom, 0);
    do_reset();
    for (int k = 0; k < 8; k++) beat($urandom, $urandom, 0);
    chk("s6_en", int4_en, 1'b1);
    chk("s6_first", out_first, 1'b1);
    chk("s6_cnt", vec_cnt, 8'd1);

    // vec_cnt saturation over a long dot product
    do_reset();
    for (int v = 0; v < 260; v++)
      for (int k = 0; k < 8; k++) beat($urandom, $urandom, 0);
    chk("sat_cnt", vec_cnt, 8'd255);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      hold     = ($urandom_range(0, 9) == 0);
      flush    = ($urandom_range(0, 29) == 0);
      in_last  = ($urandom_range(0, 9) == 0);
      in_a = $urandom; in_b = $urandom;
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
